sub_multi_arm_fire: RTL and testbench
=====================================

// Module: sub_multi_arm_fire
// PURPOSE
//  Multi-channel arm/fire latch unit; parametrised successor of the single-channel arm-then-fire flag.
//  Per channel: ARM enables the channel, FIRE sets the sticky output only when the channel is armed.
//  Adds per-channel CLEAR, an arm timeout and saturating fire counters, all behind one opcode/channel-select port.
//  Sits in the control plane; commands come from a sequencer, and the out/armed/expired vectors go to downstream logic.
// PARAMETERS
//  NCH   4    number of channels (>=1)
//  CW    2    channel-select width; must satisfy 2**CW >= NCH
//  TMO   16   arm timeout in cycles; 0 = no timeout (armed until fired or cleared)
//  CNTW  8    fire-counter width per channel
// PORTS
//  clk       in   1        clock; all state updates on rising edge
//  rst       in   1        synchronous reset, active-high
//  func      in   2        opcode: 0 NOP, 1 ARM, 2 FIRE, 3 CLEAR
//  ch        in   CW       target channel for func
//  out       out  NCH      sticky fired flag per channel (registered)
//  armed     out  NCH      channel in ARMED state (registered)
//  expired   out  NCH      one-cycle pulse: channel timed out (registered)
//  fire_cnt  out  CNTW     accepted-FIRE count of channel ch (combinational mux of registers)
// BEHAVIOUR
//  - Reset: all channels go to IDLE; out=0, armed=0, expired=0, counters=0, timers=0.
//    rst wins over any func in the same cycle and aborts any timeout in progress.
//  - One command per cycle. It applies only to channel ch; every other channel evolves autonomously.
//  - A command with ch >= NCH is ignored entirely (no state change anywhere).
//  - Per-channel FSM states: IDLE, ARMED, FIRED. Flags: armed = (ARMED); out = (FIRED).
//  - IDLE:  ARM -> ARMED, timer <= TMO-1. FIRE -> ignored (no count). CLEAR/NOP -> stay.
//  - ARMED: FIRE -> FIRED, counter +1.
//           ARM -> stay ARMED, timer reloaded to TMO-1.
//           CLEAR -> IDLE.
//           No command on this channel, TMO != 0:
//             timer==0 -> IDLE, expired[ch] = 1 for exactly one cycle.
//             otherwise timer decrements.
//  - FIRED: FIRE -> stay, counter +1. ARM -> ignored (out stays sticky). CLEAR -> IDLE.
//  - CLEAR always zeroes the channel's counter, out, armed and timer. It clears a pending expired pulse only
//    for cycles after the clear edge; the pulse already registered is not retracted.
//  - Latency: out/armed/expired update on the edge that samples the command (1-cycle registered).
//  - Timeout window: with ARM sampled at edge k, armed=1 from edge k through edge k+TMO-1 (TMO cycles).
//    A FIRE sampled at edge k+TMO is still accepted (command beats expiry); the channel drops to IDLE at
//    edge k+TMO only if no command targets it.
//  - Counter saturates at 2**CNTW-1; further accepted FIREs leave it unchanged.
//  - expired is low in every cycle other than the single pulse cycle.
//  - fire_cnt reflects the register value of channel ch in the current cycle. It is 0 when ch >= NCH.
// TESTING
//  1 rst=1 for 2 cycles with func=1 -> out=0, armed=0, expired=0, fire_cnt=0 for all ch after release.
//  2 FIRE ch0 while IDLE -> out[0]=0, fire_cnt=0. Then ARM ch0 -> armed[0]=1. FIRE ch0 -> out[0]=1,
//    armed[0]=0, fire_cnt=1. FIRE ch0 x3 more -> fire_cnt=4.
//  3 TMO=4: ARM ch1 @edge0, NOP -> armed[1]=1 after edges 0..3, 0 after edge4, expired[1]=1 only between
//    edges 4 and 5. A FIRE ch1 @edge5 is ignored. Repeat with FIRE @edge4 -> out[1]=1, no expired pulse.
//  4 TMO=4: ARM ch2 @edge0, ARM ch2 again @edge3 -> armed[2] stays 1 through edge6 and drops at edge7.
//  5 CNTW=2: ARM ch3, FIRE ch3 x5 -> fire_cnt saturates at 3. CLEAR ch3 -> out[3]=0, fire_cnt=0.
//    Then FIRE ch3 -> ignored.
//  6 NCH=3, CW=2: ARM ch3 -> no armed bit changes, fire_cnt=0. Then ARM ch0 and assert rst in the same
//    cycle -> armed[0]=0 after the edge.

Source files
------------

// File: rtl/sub_multi_arm_fire.sv
// Multi-channel arm/fire latch: per-channel IDLE/ARMED/FIRED FSM with arm timeout and saturating fire counters.
// Single command port (func/ch); flags are registered, fire_cnt is a combinational mux of the counter flops.
module sub_multi_arm_fire #(
  parameter int NCH  = 4,
  parameter int CW   = 2,
  parameter int TMO  = 16,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      func,
  input  logic [CW-1:0]   ch,
  output logic [NCH-1:0]  out,
  output logic [NCH-1:0]  armed,
  output logic [NCH-1:0]  expired,
  output logic [CNTW-1:0] fire_cnt
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TLOAD = (TMO > 0) ? TW'(TMO - 1) : '0;
  localparam logic [CW:0] NCH_L = (CW + 1)'(NCH);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    F_NOP   = 2'd0,
    F_ARM   = 2'd1,
    F_FIRE  = 2'd2,
    F_CLEAR = 2'd3
  } func_t;

  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [TW-1:0]   tmr_q   [NCH];
  logic [TW-1:0]   tmr_d   [NCH];
  logic [CNTW-1:0] cnt_q   [NCH];
  logic [CNTW-1:0] cnt_d   [NCH];
  logic [NCH-1:0]  exp_q;
  logic [NCH-1:0]  exp_d;
  logic            ch_ok;

  // Out-of-range channel selects must not alias onto a real channel.
  assign ch_ok = ({1'b0, ch} < NCH_L);

  always_comb begin
    exp_d = '0;
    for (int i = 0; i < NCH; i++) begin
      logic sel;
      logic hit_arm;
      logic hit_fire;
      logic hit_clr;
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      cnt_d[i]   = cnt_q[i];
      sel        = ch_ok && (ch == CW'(i));
      hit_arm    = sel && (func == F_ARM);
      hit_fire   = sel && (func == F_FIRE);
      hit_clr    = sel && (func == F_CLEAR);

      case (state_q[i])
        S_IDLE: begin
          if (hit_arm) begin
            state_d[i] = S_ARMED;
            tmr_d[i]   = TLOAD;
          end
        end
        S_ARMED: begin
          if (hit_fire) begin
            state_d[i] = S_FIRED;
            tmr_d[i]   = '0;
            if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNTW'(1);
          end else if (hit_arm) begin
            tmr_d[i] = TLOAD;
          end else if (!hit_clr && (TMO != 0)) begin
            // Only an untouched channel ages; any command this cycle beats expiry.
            if (tmr_q[i] == '0) begin
              state_d[i] = S_IDLE;
              exp_d[i]   = 1'b1;
            end else begin
              tmr_d[i] = tmr_q[i] - TW'(1);
            end
          end
        end
        S_FIRED: begin
          if (hit_fire && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNTW'(1);
        end
        default: begin
          state_d[i] = S_IDLE;
          tmr_d[i]   = '0;
        end
      endcase

      if (hit_clr) begin
        state_d[i] = S_IDLE;
        tmr_d[i]   = '0;
        cnt_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_IDLE;
        tmr_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      exp_q <= exp_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        tmr_q[i]   <= tmr_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      out[i]   = (state_q[i] == S_FIRED);
      armed[i] = (state_q[i] == S_ARMED);
    end
  end

  assign expired = exp_q;

  always_comb begin
    fire_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_ok && (ch == CW'(i))) fire_cnt = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_sub_multi_arm_fire.sv
// Randomized and directed bench for sub_multi_arm_fire against a deadline-based reference model.
module tb_sub_multi_arm_fire;
  localparam int NCH  = 3;
  localparam int CW   = 2;
  localparam int TMO  = 4;
  localparam int CNTW = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      func = 2'd0;
  logic [CW-1:0]   ch = '0;
  logic [NCH-1:0]  out;
  logic [NCH-1:0]  armed;
  logic [NCH-1:0]  expired;
  logic [CNTW-1:0] fire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: mode 0 idle, 1 armed, 2 fired; deadline is the absolute edge number of expiry.
  int m_mode [NCH];
  int m_cnt  [NCH];
  int m_dl   [NCH];
  bit m_exp  [NCH];
  int cyc = 0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  sub_multi_arm_fire #(.NCH(NCH), .CW(CW), .TMO(TMO), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .func     (func),
    .ch       (ch),
    .out      (out),
    .armed    (armed),
    .expired  (expired),
    .fire_cnt (fire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input int f, input int c);
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_dl[i] = 0; m_exp[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        bit hit;
        m_exp[i] = 1'b0;
        hit = (i == c) && (f != 0);
        if (hit) begin
          if (f == 1) begin
            if (m_mode[i] != 2) begin
              m_mode[i] = 1;
              m_dl[i]   = cyc + TMO;
            end
          end else if (f == 2) begin
            if (m_mode[i] != 0) begin
              m_mode[i] = 2;
              m_cnt[i]  = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
            end
          end else begin
            m_mode[i] = 0;
            m_cnt[i]  = 0;
          end
        end else if (m_mode[i] == 1 && TMO != 0 && cyc == m_dl[i]) begin
          m_mode[i] = 0;
          m_exp[i]  = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input int f, input int c);
    logic [NCH-1:0] eo, ea, ee;
    @(negedge clk);
    rst  = r;
    func = f[1:0];
    ch   = c[CW-1:0];
    #1;
    if (m_valid) chk("fire_cnt", 32'(fire_cnt), (c < NCH) ? m_cnt[c] : 0);
    @(posedge clk);
    cyc++;
    model_edge(r, f, c);
    #1;
    for (int i = 0; i < NCH; i++) begin
      eo[i] = (m_mode[i] == 2);
      ea[i] = (m_mode[i] == 1);
      ee[i] = m_exp[i];
    end
    chk("out", 32'(out), 32'(eo));
    chk("armed", 32'(armed), 32'(ea));
    chk("expired", 32'(expired), 32'(ee));
  endtask

  initial begin
    // Reset held two cycles while an ARM is presented.
    step(1'b1, 1, 0);
    step(1'b1, 1, 0);
    for (int c = 0; c < 4; c++) step(1'b0, 0, c);

    // Fire before arm, then arm/fire and repeated fires.
    step(1'b0, 2, 0);
    step(1'b0, 1, 0);
    step(1'b0, 2, 0);
    for (int k = 0; k < 3; k++) step(1'b0, 2, 0);
    step(1'b0, 0, 0);

    // Timeout with late fire ignored, then fire exactly at the expiry edge.
    step(1'b0, 1, 1);
    for (int k = 0; k < 4; k++) step(1'b0, 0, 0);
    step(1'b0, 2, 1);
    step(1'b0, 0, 1);
    step(1'b0, 3, 1);
    step(1'b0, 1, 1);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 0);
    step(1'b0, 2, 1);
    step(1'b0, 0, 1);

    // Re-arm extends the window.
    step(1'b0, 1, 2);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    step(1'b0, 1, 2);
    for (int k = 0; k < 5; k++) step(1'b0, 0, 2);

    // Counter saturation and clear.
    step(1'b0, 1, 2);
    for (int k = 0; k < 5; k++) step(1'b0, 2, 2);
    step(1'b0, 3, 2);
    step(1'b0, 2, 2);
    step(1'b0, 0, 2);

    // Out-of-range channel, then reset beats a simultaneous arm.
    step(1'b0, 1, 3);
    step(1'b0, 2, 3);
    step(1'b0, 1, 0);
    step(1'b0, 3, 0);
    step(1'b0, 1, 0);
    step(1'b1, 1, 0);
    step(1'b0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      bit r;
      int f;
      r = ($urandom_range(0, 127) == 0);
      f = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
      step(r, f, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
